// File: rtl/char_cell_plotter.sv
// Sweeps one CELL_W x CELL_H glyph cell, querying a combinational glyph LUT per
// offset and emitting framebuffer writes through a one-stage output register.
module char_cell_plotter #(
    parameter int          CELL_W    = 10,
    parameter int          CELL_H    = 10,
    parameter bit          DRAW_BG   = 1'b0,
    parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] char_code,
    input  logic [7:0] origin_x,
    input  logic [7:0] origin_y,
    output logic [5:0] glyph_code,
    output logic [7:0] glyph_dx,
    output logic [7:0] glyph_dy,
    input  logic       glyph_en,
    input  logic [5:0] glyph_colour,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [5:0] plot_colour,
    output logic       plot_write,
    input  logic       plot_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t     state_q;
    logic [5:0] code_q;
    logic [7:0] org_x_q;
    logic [7:0] org_y_q;
    logic [7:0] dx_q;
    logic [7:0] dy_q;
    logic [7:0] plot_x_q;
    logic [7:0] plot_y_q;
    logic [5:0] plot_colour_q;
    logic       plot_write_q;
    logic       busy_q;
    logic       done_q;

    logic       stall;
    logic       last_col;
    logic       last_row;
    logic       emit_d;
    logic [7:0] plot_x_d;
    logic [7:0] plot_y_d;
    logic [5:0] colour_d;

    // Valid/ready: plot_write is valid, a pixel transfers on a cycle where
    // plot_write && plot_ready; while valid and not ready everything holds.
    assign stall    = plot_write_q && !plot_ready;
    assign last_col = (dx_q == 8'(CELL_W - 1));
    assign last_row = (dy_q == 8'(CELL_H - 1));
    assign emit_d   = glyph_en || DRAW_BG;
    assign plot_x_d = org_x_q + dx_q;
    assign plot_y_d = org_y_q + dy_q;
    assign colour_d = glyph_en ? glyph_colour : BG_COLOUR;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            code_q        <= '0;
            org_x_q       <= '0;
            org_y_q       <= '0;
            dx_q          <= '0;
            dy_q          <= '0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
            plot_write_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        code_q  <= char_code;
                        org_x_q <= origin_x;
                        org_y_q <= origin_y;
                        dx_q    <= '0;
                        dy_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!stall) begin
                        plot_write_q <= emit_d;
                        if (emit_d) begin
                            plot_x_q      <= plot_x_d;
                            plot_y_q      <= plot_y_d;
                            plot_colour_q <= colour_d;
                        end
                        if (last_col) begin
                            dx_q <= '0;
                            if (last_row) begin
                                dy_q    <= '0;
                                state_q <= DRAIN;
                            end else begin
                                dy_q <= dy_q + 8'd1;
                            end
                        end else begin
                            dx_q <= dx_q + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        plot_write_q <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign glyph_code  = code_q;
    assign glyph_dx    = dx_q;
    assign glyph_dy    = dy_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_colour_q;
    assign plot_write  = plot_write_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_char_cell_plotter.sv
// Bench for char_cell_plotter: one instance without and one with background fill,
// both fed by a glyph LUT model and checked against a row-major expected pixel list.
module tb_char_cell_plotter;

    localparam logic [5:0] CH_H = 6'd17;
    localparam logic [5:0] BG1  = 6'b000011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       plot_ready = 1'b1;
    logic [5:0] char_code = '0;
    logic [7:0] origin_x = '0;
    logic [7:0] origin_y = '0;

    logic [5:0] g_code0, g_code1, g_col0, g_col1, pc0, pc1;
    logic [7:0] g_dx0, g_dx1, g_dy0, g_dy1, px0, px1, py0, py1;
    logic       g_en0, g_en1, pw0, pw1, busy0, busy1, done0, done1;
    logic [1:0] st0, st1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int s_cyc = 0;
    int done0_n = 0, done1_n = 0, done0_cyc = -1, done1_cyc = -1;

    logic [21:0] got0_q[$], got1_q[$];
    logic [21:0] exp0_q[$], exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Glyph LUT: 'H' is a fixed shape; other codes use an arithmetic pattern.
    function automatic logic glyph_en_f(input logic [5:0] c, input logic [7:0] dx, input logic [7:0] dy);
        int x, y;
        x = int'(dx);
        y = int'(dy);
        if (c == CH_H) return (x == 2 || x == 7) || (y == 5 && x >= 3 && x <= 6);
        return ((int'(c) + 3 * x + 5 * y) % 4) == 0;
    endfunction

    function automatic logic [5:0] glyph_col_f(input logic [5:0] c, input logic [7:0] dx, input logic [7:0] dy);
        if (c == CH_H) return 6'h3f;
        return 6'((int'(c) * 5 + int'(dx) + 7 * int'(dy)) % 63 + 1);
    endfunction

    assign g_en0  = glyph_en_f(g_code0, g_dx0, g_dy0);
    assign g_col0 = glyph_col_f(g_code0, g_dx0, g_dy0);
    assign g_en1  = glyph_en_f(g_code1, g_dx1, g_dy1);
    assign g_col1 = glyph_col_f(g_code1, g_dx1, g_dy1);

    char_cell_plotter #(.CELL_W(10), .CELL_H(10), .DRAW_BG(1'b0), .BG_COLOUR(6'b000000)) dut0 (
        .clk(clk), .reset(reset), .start(start), .char_code(char_code),
        .origin_x(origin_x), .origin_y(origin_y),
        .glyph_code(g_code0), .glyph_dx(g_dx0), .glyph_dy(g_dy0),
        .glyph_en(g_en0), .glyph_colour(g_col0),
        .plot_x(px0), .plot_y(py0), .plot_colour(pc0), .plot_write(pw0),
        .plot_ready(plot_ready), .busy(busy0), .done(done0), .dbg_state(st0)
    );

    char_cell_plotter #(.CELL_W(10), .CELL_H(10), .DRAW_BG(1'b1), .BG_COLOUR(BG1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .char_code(char_code),
        .origin_x(origin_x), .origin_y(origin_y),
        .glyph_code(g_code1), .glyph_dx(g_dx1), .glyph_dy(g_dy1),
        .glyph_en(g_en1), .glyph_colour(g_col1),
        .plot_x(px1), .plot_y(py1), .plot_colour(pc1), .plot_write(pw1),
        .plot_ready(plot_ready), .busy(busy1), .done(done1), .dbg_state(st1)
    );

    // Transfer and done monitor, sampled mid-cycle after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (pw0 && plot_ready) got0_q.push_back({px0, py0, pc0});
        if (pw1 && plot_ready) got1_q.push_back({px1, py1, pc1});
        if (done0) begin done0_n++; done0_cyc = cyc; end
        if (done1) begin done1_n++; done1_cyc = cyc; end
    end

    task automatic build_exp(input logic [5:0] code, input logic [7:0] ox, input logic [7:0] oy);
        exp0_q.delete();
        exp1_q.delete();
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                logic [7:0] ax, ay;
                logic en;
                logic [5:0] col;
                ax  = 8'((int'(ox) + x) % 256);
                ay  = 8'((int'(oy) + y) % 256);
                en  = glyph_en_f(code, 8'(x), 8'(y));
                col = glyph_col_f(code, 8'(x), 8'(y));
                if (en) exp0_q.push_back({ax, ay, col});
                exp1_q.push_back({ax, ay, en ? col : BG1});
            end
        end
    endtask

    task automatic launch(input logic [5:0] code, input logic [7:0] ox, input logic [7:0] oy);
        @(negedge clk);
        got0_q.delete(); got1_q.delete();
        done0_n = 0; done1_n = 0; done0_cyc = -1; done1_cyc = -1;
        char_code = code; origin_x = ox; origin_y = oy; start = 1'b1;
        s_cyc = cyc;
        build_exp(code, ox, oy);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({g_code0, g_dx0, g_dy0, px0, py0, pc0, pw0, busy0, done0} !== 47'd0) begin
            n_err++;
            $display("FAIL reset0: got %h want 0", {g_code0, g_dx0, g_dy0, px0, py0, pc0, pw0, busy0, done0});
        end
        n_cmp++;
        if ({g_code1, g_dx1, g_dy1, px1, py1, pc1, pw1, busy1, done1} !== 47'd0) begin
            n_err++;
            $display("FAIL reset1: got %h want 0", {g_code1, g_dx1, g_dy1, px1, py1, pc1, pw1, busy1, done1});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_h_glyph();
        launch(CH_H, 8'd20, 8'd30);
        n_cmp++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_err++; $display("FAIL h_busy: got %b%b want 11", busy0, busy1);
        end
        @(negedge clk);
        n_cmp++;
        if ({pw1, px1, py1} !== {1'b1, 8'd20, 8'd30}) begin
            n_err++; $display("FAIL h_first_pixel: got %h want %h", {pw1, px1, py1}, {1'b1, 8'd20, 8'd30});
        end
        for (int k = 0; k < 300 && (done0_n == 0 || done1_n == 0); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got0_q.size() !== 24 || exp0_q.size() !== 24) begin
            n_err++; $display("FAIL h_count0: got %0d want 24", got0_q.size());
        end
        n_cmp++;
        if (got1_q.size() !== 100) begin
            n_err++; $display("FAIL h_count1: got %0d want 100", got1_q.size());
        end
        for (int i = 0; i < exp0_q.size() && i < got0_q.size(); i++) begin
            n_cmp++;
            if (got0_q[i] !== exp0_q[i]) begin n_err++; $display("FAIL h_pix0[%0d]: got %h want %h", i, got0_q[i], exp0_q[i]); end
        end
        for (int i = 0; i < exp1_q.size() && i < got1_q.size(); i++) begin
            n_cmp++;
            if (got1_q[i] !== exp1_q[i]) begin n_err++; $display("FAIL h_pix1[%0d]: got %h want %h", i, got1_q[i], exp1_q[i]); end
        end
        n_cmp++;
        if (done0_n !== 1 || done1_n !== 1) begin
            n_err++; $display("FAIL h_done_count: got %0d/%0d want 1/1", done0_n, done1_n);
        end
        n_cmp++;
        if (done0_cyc !== s_cyc + 102 || done1_cyc !== s_cyc + 102) begin
            n_err++; $display("FAIL h_done_cycle: got %0d/%0d want %0d", done0_cyc - s_cyc, done1_cyc - s_cyc, 102);
        end
        n_cmp++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            n_err++; $display("FAIL h_busy_after: got %b%b want 00", busy0, busy1);
        end
    endtask

    task automatic test_stall();
        logic [22:0] hold;
        bit found;
        launch(CH_H, 8'($urandom_range(0, 200)), 8'($urandom_range(0, 200)));
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (pw0 && got0_q.size() == 2) found = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL stall_find_third: got none want write 3"); end
        hold = {px0, py0, pc0, pw0};
        plot_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) plot_ready = 1'b1;
            n_cmp++;
            if ({px0, py0, pc0, pw0} !== hold) begin
                n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", k, {px0, py0, pc0, pw0}, hold);
            end
        end
        for (int k = 0; k < 300 && (done0_n == 0 || done1_n == 0); k++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got0_q !== exp0_q) begin n_err++; $display("FAIL stall_list0: got %0d writes want %0d", got0_q.size(), exp0_q.size()); end
        n_cmp++;
        if (got1_q !== exp1_q) begin n_err++; $display("FAIL stall_list1: got %0d writes want %0d", got1_q.size(), exp1_q.size()); end
        n_cmp++;
        if (done0_cyc !== s_cyc + 107 || done1_cyc !== s_cyc + 107 || done0_n !== 1) begin
            n_err++; $display("FAIL stall_done_cycle: got %0d/%0d want 107", done0_cyc - s_cyc, done1_cyc - s_cyc);
        end
    endtask

    task automatic test_busy_start();
        logic [7:0] ox, oy;
        int d;
        ox = 8'($urandom_range(0, 255));
        oy = 8'($urandom_range(0, 255));
        launch(6'($urandom_range(0, 63)), ox, oy);
        for (int k = 0; k < 110; k++) begin
            @(negedge clk);
            d = cyc - s_cyc;
            start = (d == 5 || d == 50 || d == 101 || d == 102);
            origin_x = ~ox;
            origin_y = oy + 8'd33;
            char_code = 6'(d);
        end
        start = 1'b0;
        n_cmp++;
        if (got0_q !== exp0_q) begin n_err++; $display("FAIL busy_start_list0: got %0d writes want %0d", got0_q.size(), exp0_q.size()); end
        n_cmp++;
        if (got1_q !== exp1_q) begin n_err++; $display("FAIL busy_start_list1: got %0d writes want %0d", got1_q.size(), exp1_q.size()); end
        n_cmp++;
        if (done0_n !== 1 || done1_n !== 1 || done0_cyc !== s_cyc + 102) begin
            n_err++; $display("FAIL busy_start_done: got %0d/%0d at %0d want 1/1 at 102", done0_n, done1_n, done0_cyc - s_cyc);
        end
        n_cmp++;
        if ({busy0, busy1, pw0, pw1} !== 4'b0000) begin
            n_err++; $display("FAIL busy_start_idle: got %b want 0000", {busy0, busy1, pw0, pw1});
        end
    endtask

    task automatic test_wrap();
        launch(CH_H, 8'd250, 8'd252);
        for (int k = 0; k < 300 && (done0_n == 0 || done1_n == 0); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (got0_q !== exp0_q) begin n_err++; $display("FAIL wrap_list0: got %0d writes want %0d", got0_q.size(), exp0_q.size()); end
        n_cmp++;
        if (got1_q !== exp1_q) begin n_err++; $display("FAIL wrap_list1: got %0d writes want %0d", got1_q.size(), exp1_q.size()); end
        n_cmp++;
        if (got0_q.size() == 0 || got0_q[got0_q.size() - 1] !== {8'd1, 8'd5, 6'h3f}) begin
            n_err++; $display("FAIL wrap_last: got %h want %h", (got0_q.size() == 0) ? 22'h0 : got0_q[got0_q.size() - 1], {8'd1, 8'd5, 6'h3f});
        end
    endtask

    task automatic test_reset_mid();
        launch(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int k = 0; k < 200 && got1_q.size() < 39; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({pw0, pw1, busy0, busy1, done0, done1} !== 6'b0) begin
            n_err++; $display("FAIL reset_mid_outputs: got %b want 000000", {pw0, pw1, busy0, busy1, done0, done1});
        end
        repeat (120) @(negedge clk);
        n_cmp++;
        if (done0_n !== 0 || done1_n !== 0 || busy0 !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_no_done: got %0d/%0d want 0/0", done0_n, done1_n);
        end
        launch(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        for (int k = 0; k < 300 && (done0_n == 0 || done1_n == 0); k++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (got0_q !== exp0_q) begin n_err++; $display("FAIL reset_mid_rerun0: got %0d writes want %0d", got0_q.size(), exp0_q.size()); end
        n_cmp++;
        if (got1_q !== exp1_q) begin n_err++; $display("FAIL reset_mid_rerun1: got %0d writes want %0d", got1_q.size(), exp1_q.size()); end
        n_cmp++;
        if (done0_cyc !== s_cyc + 102 || done1_n !== 1) begin
            n_err++; $display("FAIL reset_mid_rerun_done: got %0d want 102", done0_cyc - s_cyc);
        end
    endtask

    task automatic test_random_backpressure();
        for (int it = 0; it < 3; it++) begin
            launch(6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            for (int k = 0; k < 1000 && (done0_n == 0 || done1_n == 0); k++) begin
                plot_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
            end
            plot_ready = 1'b1;
            repeat (3) @(negedge clk);
            n_cmp++;
            if (got0_q !== exp0_q) begin n_err++; $display("FAIL bp_list0[%0d]: got %0d writes want %0d", it, got0_q.size(), exp0_q.size()); end
            n_cmp++;
            if (got1_q !== exp1_q) begin n_err++; $display("FAIL bp_list1[%0d]: got %0d writes want %0d", it, got1_q.size(), exp1_q.size()); end
            n_cmp++;
            if (done0_n !== 1 || done1_n !== 1) begin
                n_err++; $display("FAIL bp_done[%0d]: got %0d/%0d want 1/1", it, done0_n, done1_n);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_h_glyph();
        test_stall();
        test_busy_start();
        test_wrap();
        test_reset_mid();
        test_random_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
